// File: rtl/dn_multich_write_ctrl.sv
// dn_multich_write_ctrl: streams one iteration's DN IB-ROM page set into the DN IB-RAMs for CH_NUM channels.
// Define DN_WR_AUTO_ITER_EN to take the load index from an internal wrapping counter instead of iter_idx.
module dn_multich_write_ctrl #(
   parameter int CH_NUM         = 4,
   parameter int ROM_RD_BW      = 2,
   parameter int ROM_ADDR_BW    = 11,
   parameter int PAGE_ADDR_BW   = 6,
   parameter int DN_LOAD_CYCLE  = 64,
   parameter int ITER_ROM_GROUP = 25,
   parameter int MAX_ITER       = 50,
   parameter int ITER_ADDR_BW   = 6
) (
   input  logic                        write_clk,
   input  logic                        rstn,
   input  logic                        iter_load_req,
   input  logic [ITER_ADDR_BW-1:0]     iter_idx,
   input  logic [CH_NUM*ROM_RD_BW-1:0] rom0_din,
   input  logic [CH_NUM*ROM_RD_BW-1:0] rom1_din,
   output logic                        rom_rd_en,
   output logic [ROM_ADDR_BW-1:0]      rom_rd_addr,
   output logic                        ram_wr_en,
   output logic [PAGE_ADDR_BW-1:0]     ram_wr_addr,
   output logic [CH_NUM*ROM_RD_BW-1:0] ram_wr_data,
   output logic                        busy,
   output logic                        iter_load_done,
   output logic                        req_err
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [ITER_ADDR_BW-1:0] GRP_SIZE = ITER_ADDR_BW'(ITER_ROM_GROUP);
   localparam logic [PAGE_ADDR_BW-1:0] LAST_PAGE = PAGE_ADDR_BW'(DN_LOAD_CYCLE - 1);
   state_t state, state_nxt;
   logic grp;
   logic [ITER_ADDR_BW-1:0] local_idx, load_idx;
   logic [PAGE_ADDR_BW-1:0] page;
   logic idx_ok, accept, last_page;
`ifdef DN_WR_AUTO_ITER_EN
   logic [ITER_ADDR_BW-1:0] auto_idx;
   always_ff @(posedge write_clk or negedge rstn)
      if (!rstn) auto_idx <= '0;
      else if (state == DONE) auto_idx <= (auto_idx == ITER_ADDR_BW'(MAX_ITER - 1)) ? '0 : auto_idx + 1'b1;
   assign load_idx = auto_idx;
   assign idx_ok = 1'b1;
`else
   assign load_idx = iter_idx;
   assign idx_ok = 32'(iter_idx) < MAX_ITER;
`endif
   assign accept = iter_load_req && state == IDLE && idx_ok;
   assign last_page = page == LAST_PAGE;
   always_ff @(posedge write_clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = (state == IDLE) ? (accept ? RUN : IDLE) :
                  (state == RUN) ? (last_page ? DRAIN : RUN) :
                  (state == DRAIN) ? DONE : IDLE;
   end
   always_comb begin
      rom_rd_en = state == RUN;
      busy = state != IDLE;
      iter_load_done = state == DONE;
   end
   // Address is derived from held registers, so it keeps its last value while idle.
   assign rom_rd_addr = ROM_ADDR_BW'(local_idx) * ROM_ADDR_BW'(DN_LOAD_CYCLE) + ROM_ADDR_BW'(page);
   always_ff @(posedge write_clk or negedge rstn)
      if (!rstn) begin
         grp <= 1'b0;
         local_idx <= '0;
         page <= '0;
         ram_wr_en <= 1'b0;
         ram_wr_addr <= '0;
         ram_wr_data <= '0;
         req_err <= 1'b0;
      end else begin
         req_err <= iter_load_req && !accept;
         if (accept) begin
            grp <= load_idx >= GRP_SIZE;
            local_idx <= (load_idx >= GRP_SIZE) ? load_idx - GRP_SIZE : load_idx;
            page <= '0;
         end else if (rom_rd_en && !last_page) page <= page + 1'b1;
         // ROM data for the address presented this cycle is captured on this edge.
         ram_wr_en <= rom_rd_en;
         if (rom_rd_en) begin
            ram_wr_addr <= page;
            ram_wr_data <= grp ? rom1_din : rom0_din;
         end
      end
endmodule
